pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised, elastic successor to the fixed decode/execute pipeline register. It is one pipeline stage with valid/ready handshakes on both sides and a two-entry skid buffer, so back-pressure is registered rather than combinational. It has a synchronous flush that inserts bubbles, and the payload is split into a control field (zeroed on bubble) and a data field. It sits between any two pipeline stages, e.g. decode and execute, replacing the EN/CLR register pair.

## Interface
Parameters:
- DATA_W, 32, width of datapath payload (operands, immediates, PC values)
- CTRL_W, 16, width of control payload (write enables, opcodes, selects); forced to zero whenever the slot is not valid

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush; empties the stage
- in_valid  in  1  upstream has a word
- in_ready  out  1  stage can accept a word
- in_ctrl  in  CTRL_W  upstream control payload
- in_data  in  DATA_W  upstream data payload
- out_valid  out  1  stage presents a word
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control payload; 0 when out_valid=0
- out_data  out  DATA_W  data payload
- occupancy  out  2  number of held words, 0..2

## Operation
- Storage: a main entry driving the outputs, and a skid entry.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Three states: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- in_ready = !skid_valid, driven directly from a flop; no combinational path from out_ready.
- out_valid = main_valid.
- EMPTY:
  - in_fire -> ONE; main <= in.
  - Otherwise stay EMPTY.
- ONE:
  - in_fire & out_fire -> ONE; main <= in.
  - in_fire only -> FULL; skid <= in.
  - out_fire only -> EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready = 0.
  - out_fire -> ONE; main <= skid.
  - Otherwise hold.
- Flush:
  - Highest priority; next state is EMPTY.
  - A simultaneous in_fire word is discarded.
  - A simultaneous out_fire is a completed transfer; downstream keeps it.
  - Both valid bits and both ctrl fields are cleared.
- Ordering is strictly FIFO; no word is duplicated or dropped except by flush.
- Control field of any invalid entry is held at 0, so a bubble is a NOP downstream.

## Timing
- Reset (async assert, sync release): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid cleared, in_ready=1.
- Latency: a word accepted at edge N is on the outputs after edge N; out_valid is high in cycle N+1.
- Throughput: 1 word/cycle while out_ready=1.
- Back-pressure: out_ready low for one cycle while ONE and in_valid high -> FULL. in_ready drops the following cycle; no word is lost.
- Back-pressure release: in_ready returns high the cycle after the FULL -> ONE transition.
- Reset mid-transfer: all held words are lost; outputs go to reset values immediately.
- Flush and rst both asserted: rst dominates.

## Configuration
- PIPE_STAGE_DATA_CLR_EN:
  - Defined: flush and reset also zero data in both entries. Every out_data bubble reads 0, which eases waveform debug.
  - Undefined: data flops have no flush path and keep stale values under a bubble. Only valid and ctrl are cleared, saving area and power.
  - Reset still clears out_data in both builds.

## Test plan
- Reset then stream: rst pulse, in_valid=1, out_ready=1, data 0x1..0x8 -> outputs 0x1..0x8 on consecutive cycles from 1 cycle later; occupancy=1 throughout; in_ready=1.
- Stall: out_ready=0 for 3 cycles during a stream of 0xA, 0xB, 0xC -> occupancy reaches 2 and in_ready=0. 0xA is held on the outputs. After release, 0xA, 0xB, 0xC emerge in order with none lost or duplicated.
- Flush while FULL: occupancy=2, pulse flush with in_valid=1 (0xDEAD) -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xDEAD never appears. With PIPE_STAGE_DATA_CLR_EN, out_data=0.
- Simultaneous fire in ONE: main holds 0x5; in=0x6, out_ready=1 -> 0x5 consumed, next cycle out_data=0x6, occupancy=1.
- Async reset mid-stream: assert rst between edges while FULL -> out_valid, out_ctrl and occupancy go to 0 without waiting for a clock edge; in_ready=1.
- Randomised valid/ready at 50%, 2000 words, scoreboard -> order preserved and out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage with two-entry skid buffer; define PIPE_STAGE_DATA_CLR_EN to zero data on flush
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic in_fire, out_fire, ld_in, ld_sm, ld_skid, clr_main, clr_skid;
  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign occupancy = {state[1], state[0] & ~state[1]};
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    ld_in    = 1'b0;
    ld_sm    = 1'b0;
    ld_skid  = 1'b0;
    clr_main = 1'b0;
    clr_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state_nx = ONE;
          ld_in    = 1'b1;
        end
        ONE: if (in_fire && out_fire) ld_in = 1'b1;
          else if (in_fire) begin
            state_nx = FULL;
            ld_skid  = 1'b1;
          end else if (out_fire) begin
            state_nx = EMPTY;
            clr_main = 1'b1;
          end
        FULL: if (out_fire) begin
          state_nx = ONE;
          ld_sm    = 1'b1;
          clr_skid = 1'b1;
        end
        default: begin
          state_nx = EMPTY;
          clr_main = 1'b1;
          clr_skid = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nx;
      main_ctrl <= ld_in ? in_ctrl : ld_sm ? skid_ctrl : clr_main ? '0 : main_ctrl;
      skid_ctrl <= ld_skid ? in_ctrl : clr_skid ? '0 : skid_ctrl;
`ifdef PIPE_STAGE_DATA_CLR_EN
      main_data <= flush ? '0 : ld_in ? in_data : ld_sm ? skid_data : main_data;
      skid_data <= flush ? '0 : ld_skid ? in_data : skid_data;
`else
      main_data <= ld_in ? in_data : ld_sm ? skid_data : main_data;
      skid_data <= ld_skid ? in_data : skid_data;
`endif
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomised scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int CW = 16;
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [CW+DW-1:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit zero_exp = 1'b1;
  bit saw_full = 1'b0;
  bit rnd_ready = 1'b0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted words, capacity two, evaluated
  // mid-cycle when inputs and outputs are both stable.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_out_ctrl", 64'(out_ctrl), 0);
      check("rst_out_data", 64'(out_data), 0);
      check("rst_occupancy", 64'(occupancy), 0);
      check("rst_in_ready", 64'(in_ready), 1);
      q.delete();
      zero_exp = 1'b1;
    end else begin
      automatic int sz = q.size();
      check("occupancy", 64'(occupancy), 64'(sz));
      check("in_ready", 64'(in_ready), 64'(sz < 2));
      check("out_valid", 64'(out_valid), 64'(sz != 0));
      if (sz != 0) check("out_word", 64'({out_ctrl, out_data}), 64'(q[0]));
      else begin
        check("bubble_ctrl", 64'(out_ctrl), 0);
        if (zero_exp) check("bubble_data", 64'(out_data), 0);
      end
      if (occupancy == 2'd2) saw_full = 1'b1;
      if (sz != 0 && out_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
`ifdef PIPE_STAGE_DATA_CLR_EN
        zero_exp = 1'b1;
`endif
      end else if (in_valid && sz < 2) begin
        q.push_back({in_ctrl, in_data});
        zero_exp = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_ctrl = c;
    in_data = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) send(CW'(16'h100 + i), DW'(i));
    idle(3);
    out_ready = 1'b0;
    fork
      begin
        send(16'h0a0a, 32'hA);
        send(16'h0b0b, 32'hB);
        send(16'h0c0c, 32'hC);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);
    check("stall_reached_full", 64'(saw_full), 1);
    out_ready = 1'b0;
    send(16'h1111, 32'h11);
    send(16'h1212, 32'h12);
    in_valid = 1'b1;
    in_ctrl = 16'hbeef;
    in_data = 32'hDEAD;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;
    send(16'h0505, 32'h5);
    out_ready = 1'b1;
    send(16'h0606, 32'h6);
    idle(3);
    out_ready = 1'b0;
    send(16'h2121, 32'h21);
    send(16'h2222, 32'h22);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 0);
    check("arst_out_ctrl", 64'(out_ctrl), 0);
    check("arst_occupancy", 64'(occupancy), 0);
    check("arst_in_ready", 64'(in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    rnd_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send(CW'($urandom), DW'($urandom));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        idle(1);
        n++;
      end
    end
    idle(2);
    check("drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
